rbi_ring_stop_q: RTL
====================

// Module: rbi_ring_stop_q
// PURPOSE
//  Parametrised ringbus stop for the L2 segment: one registered ring hop plus a
//  local node port with a DEPTH-entry inject queue.
//  Ejects flits addressed to the node; injects queued flits into null slots.
//  Replaces hard-wired node chaining; instantiated once per L2 node (DC, ROM, MMIO).
//  Flit = {seq[15:0], opm[15:0], addr[ADDR_W-1:0], data[DATA_W-1:0]}, FLIT_W = 32+ADDR_W+DATA_W.
// PARAMETERS
//  ADDR_W    48          ring address width
//  DATA_W    128         ring data (tile) width
//  DEPTH     4           inject queue entries (power of 2, >=2)
//  BASE      48'h0       first request address owned by node
//  SIZE      48'h1000000 bytes owned; request match = BASE <= addr < BASE+SIZE
//  WD_LIMIT  1024        starvation watchdog threshold (cycles)
// PORTS
//  clock           in   1          ring clock
//  reset           in   1          asynchronous, active-low
//  ringFlitIn      in   FLIT_W     flit from previous stop
//  ringFlitOut     out  FLIT_W     registered flit to next stop
//  unitNodeId      in   8          this node's id
//  timers          in   8          timer signals; bit 0 stamped into injected opm[15]
//  txFlit          in   FLIT_W     local flit to inject
//  txValid         in   1          txFlit valid
//  txReady         out  1          queue not full
//  rxFlit          out  FLIT_W     ejected flit (registered)
//  rxValid         out  1          rxFlit valid
//  rxReady         in   1          node accepts rxFlit
//  txCount         out  $clog2(DEPTH)+1  queue occupancy
//  deadlockStrobe  out  1          one-cycle pulse: queue starved WD_LIMIT cycles
// BEHAVIOUR
//  Reset (reset==0, async): ringFlitOut=0, rxFlit=0, rxValid=0, queue empty,
//   txCount=0, txReady=1, watchdog=0, deadlockStrobe=0.
//  Null slot: opm[7:0]==8'h00. Response: opm[7:6]==2'b01.
//  Match: response with seq[15:8]==unitNodeId, or non-null non-response with addr in range.
//  Eject condition: match && (!rxValid || rxReady). Ejected flit -> rxFlit/rxValid next
//   cycle; slot becomes null this cycle. Match without eject room: flit passes unchanged
//   (circulates), never dropped.
//  rx holds flit until rxValid&&rxReady; new eject may load in same cycle as consume.
//  Inject: if post-eject slot null and queue non-empty, head goes out, opm[15]=timers[0];
//   same cycle as eject allowed (slot reuse).
//  Otherwise ringFlitOut <= ringFlitIn. Ring latency exactly 1 cycle every path.
//  Queue: FIFO, ptrs wrap mod DEPTH; push on txValid&&txReady; push+pop when full legal
//   only if pop occurs (txReady stays 0 when full, no same-cycle bypass). Empty queue,
//   push never injects same cycle (min tx->ring latency 2 cycles).
//  Watchdog: counts cycles queue non-empty and no inject; clears on inject or empty;
//   at WD_LIMIT-1 -> deadlockStrobe=1 one cycle, counter to 0. Informational only.
//  Flits not matched/null pass bit-exact (opm[15] untouched).
// STRUCTURE
//  rbi_ring_pkg: FLIT_W function, field offsets, OPM null/response masks, opm LDX/STX/
//   PFX/SPX constants shared with other L2 nodes.
//  Sub-module: rbi_flit_fifo (DEPTH x FLIT_W, count, full/empty); rest in top level.
// TESTING
//  Reset mid-traffic: assert reset with 3 queued, rxValid=1 -> all outputs 0, txReady=1 immediately.
//  Pass-through: null-free flit opm=8'h12 addr=BASE+SIZE -> ringFlitOut equal next cycle.
//  Eject+inject: request addr=BASE+0x40, queue head opm=0x11 -> rxFlit=request,
//   ringFlitOut=head with opm[15]=timers[0], same cycle.
//  Backpressure: rxReady=0, rxValid=1, matching response seq=0x8201, id=0x82 -> flit
//   forwarded on ring unchanged, rxFlit unchanged.
//  Queue full: push 4 (DEPTH=4) with no null slots -> txReady=0, txCount=4; one null
//   slot -> first pushed flit out, txCount=3.
//  Watchdog: WD_LIMIT=16, queue non-empty, ring saturated -> deadlockStrobe pulse cycle 16, 32.

Source files
------------

// File: rtl/rbi_ring_stop_q_pkg.sv
// Purpose : shared ringbus definitions for L2 stops (flit layout, opm masks, opcodes).
// Latency : n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Flit layout, MSB first: {seq[15:0], opm[15:0], addr[ADDR_W-1:0], data[DATA_W-1:0]}.
package rbi_ring_stop_q_pkg;

  localparam int SEQ_W = 16;
  localparam int OPM_W = 16;

  // Low byte of opm all-zero marks an empty slot; opm[7:6]==01 marks a response.
  localparam logic [15:0] OPM_NULL_MASK = 16'h00FF;
  localparam logic [15:0] OPM_RESP_MASK = 16'h00C0;
  localparam logic [15:0] OPM_RESP_VAL  = 16'h0040;

  // opm bit that carries the timer stamp of an injected flit.
  localparam int OPM_STAMP_BIT = 15;

  // Request opcodes shared by every L2 node (low opm byte).
  localparam logic [7:0] OPM_LDX = 8'h10;
  localparam logic [7:0] OPM_STX = 8'h11;
  localparam logic [7:0] OPM_PFX = 8'h12;
  localparam logic [7:0] OPM_SPX = 8'h13;

  function automatic int flitW(input int addrW, input int dataW);
    return SEQ_W + OPM_W + addrW + dataW;
  endfunction

  function automatic int addrLo(input int dataW);
    return dataW;
  endfunction

  function automatic int opmLo(input int addrW, input int dataW);
    return dataW + addrW;
  endfunction

  function automatic int seqLo(input int addrW, input int dataW);
    return dataW + addrW + OPM_W;
  endfunction

  function automatic logic opmIsNull(input logic [15:0] opm);
    return (opm & OPM_NULL_MASK) == 16'h0000;
  endfunction

  function automatic logic opmIsResp(input logic [15:0] opm);
    return (opm & OPM_RESP_MASK) == OPM_RESP_VAL;
  endfunction

endpackage

// File: rtl/rbi_ring_stop_q_if.sv
// Purpose : local node port of a ring stop (inject queue side + eject side).
// Latency : n/a (wires only).
// Backpressure: txReady gates tx pushes; rxReady holds rxFlit in the stop.
// Ports   : txFlit/txValid/txReady, rxFlit/rxValid/rxReady, txCount, deadlockStrobe.
//           master = node logic, slave = ring stop.
interface rbi_ring_stop_q_if #(
  parameter int FLIT_W = 208,
  parameter int CNT_W  = 3
);
  logic [FLIT_W-1:0] txFlit;
  logic              txValid;
  logic              txReady;
  logic [FLIT_W-1:0] rxFlit;
  logic              rxValid;
  logic              rxReady;
  logic [CNT_W-1:0]  txCount;
  logic              deadlockStrobe;

  modport master (
    output txFlit, txValid, rxReady,
    input  txReady, rxFlit, rxValid, txCount, deadlockStrobe
  );

  modport slave (
    input  txFlit, txValid, rxReady,
    output txReady, rxFlit, rxValid, txCount, deadlockStrobe
  );
endinterface

// File: rtl/rbi_ring_stop_q_fifo.sv
// Purpose : generic DEPTH x WIDTH flit FIFO with occupancy count.
// Latency : 1 cycle push-to-head (no same-cycle bypass from push to headData).
// Backpressure: push ignored when full, pop ignored when empty.
// Ports   : clock, reset (async active-low), push/pushData, pop, headData, count, full, empty.
module rbi_flit_fifo #(
  parameter int WIDTH = 208,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign doPush   = push && !full;
  assign doPop    = pop && !empty;
  assign headData = mem[rdPtr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/rbi_ring_stop_q.sv
// Purpose : L2 ringbus stop - one registered hop, ejects flits owned by this node,
//           injects queued local flits into empty slots.
// Latency : exactly 1 cycle ring-in to ring-out on every path; tx-to-ring >= 2 cycles.
// Backpressure: owned flit keeps circulating while rx is full; txReady low when queue full.
// Ports   : clock, reset (async active-low), ringFlitIn/ringFlitOut, unitNodeId, timers,
//           node (slave modport: tx queue, rx register, txCount, deadlockStrobe).
module rbi_ring_stop_q
  import rbi_ring_stop_q_pkg::*;
#(
  parameter int                ADDR_W   = 48,
  parameter int                DATA_W   = 128,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] BASE     = '0,
  parameter logic [ADDR_W-1:0] SIZE     = 'h1000000,
  parameter int                WD_LIMIT = 1024,
  localparam int               FLIT_W   = flitW(ADDR_W, DATA_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [FLIT_W-1:0] ringFlitIn,
  output logic [FLIT_W-1:0] ringFlitOut,
  input  logic [7:0]        unitNodeId,
  input  logic [7:0]        timers,
  rbi_ring_stop_q_if.slave  node
);

  localparam int ADDR_LO = addrLo(DATA_W);
  localparam int OPM_LO  = opmLo(ADDR_W, DATA_W);
  localparam int SEQ_LO  = seqLo(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int WD_W    = $clog2(WD_LIMIT + 1);

  logic [OPM_W-1:0]  inOpm;
  logic [SEQ_W-1:0]  inSeq;
  logic [ADDR_W-1:0] inAddr;
  logic              inNull;
  logic              inResp;
  logic              addrHit;
  logic              match;
  logic              eject;
  logic              inject;
  logic              starved;

  logic [FLIT_W-1:0] headFlit;
  logic [FLIT_W-1:0] headStamped;
  logic [FLIT_W-1:0] ringNext;
  logic [CNT_W-1:0]  qCount;
  logic              qFull;
  logic              qEmpty;

  logic [FLIT_W-1:0] rxFlitQ;
  logic              rxValidQ;
  logic [WD_W-1:0]   wdCnt;
  logic              strobeQ;

  assign inOpm  = ringFlitIn[OPM_LO +: OPM_W];
  assign inSeq  = ringFlitIn[SEQ_LO +: SEQ_W];
  assign inAddr = ringFlitIn[ADDR_LO +: ADDR_W];
  assign inNull = opmIsNull(inOpm);
  assign inResp = opmIsResp(inOpm);

  // Offset form avoids overflow of BASE+SIZE at the top of the address space.
  assign addrHit = (inAddr >= BASE) && ((inAddr - BASE) < SIZE);

  // Responses are routed by the requester id in seq[15:8]; requests by address.
  assign match  = inResp ? (inSeq[15:8] == unitNodeId) : (!inNull && addrHit);
  assign eject  = match && (!rxValidQ || node.rxReady);
  // An ejected slot is free for reuse in the same cycle.
  assign inject = (inNull || eject) && !qEmpty;

  always_comb begin
    headStamped = headFlit;
    headStamped[OPM_LO + OPM_STAMP_BIT] = timers[0];
    ringNext = ringFlitIn;
    if (inject) begin
      ringNext = headStamped;
    end else if (eject) begin
      ringNext = '0;
    end
  end

  rbi_flit_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (DEPTH)
  ) uFifo (
    .clock    (clock),
    .reset    (reset),
    .push     (node.txValid),
    .pushData (node.txFlit),
    .pop      (inject),
    .headData (headFlit),
    .count    (qCount),
    .full     (qFull),
    .empty    (qEmpty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ringFlitOut <= '0;
      rxFlitQ     <= '0;
      rxValidQ    <= 1'b0;
    end else begin
      ringFlitOut <= ringNext;
      // A consume and a new eject may coincide; the new flit wins.
      if (eject) begin
        rxFlitQ  <= ringFlitIn;
        rxValidQ <= 1'b1;
      end else if (node.rxReady) begin
        rxValidQ <= 1'b0;
      end
    end
  end

  // Counts cycles the queue waits for a free slot; pulses once every WD_LIMIT such cycles.
  assign starved = !qEmpty && !inject;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdCnt   <= '0;
      strobeQ <= 1'b0;
    end else if (!starved) begin
      wdCnt   <= '0;
      strobeQ <= 1'b0;
    end else if (wdCnt == WD_W'(WD_LIMIT - 1)) begin
      wdCnt   <= '0;
      strobeQ <= 1'b1;
    end else begin
      wdCnt   <= wdCnt + WD_W'(1);
      strobeQ <= 1'b0;
    end
  end

  assign node.txReady        = !qFull;
  assign node.txCount        = qCount;
  assign node.rxFlit         = rxFlitQ;
  assign node.rxValid        = rxValidQ;
  assign node.deadlockStrobe = strobeQ;

endmodule
